vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Generates the raster scan that drives the display pipeline: horizontal/vertical pixel counters, HSYNC/VSYNC, active-video flag, and line/frame strobes.
- Its h_readwire/v_readwire outputs feed the screen-region decoder and the board, preview and score renderers.
- Derives the pixel rate from the system clock with an internal clock-enable divider; no second clock domain.
- A configurable delay on sync/active aligns them with downstream pixel-pipeline latency.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 2, system clocks per pixel (legal range 1..8)
SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
PIPE_DLY, 1, pixel-enable stages of delay on hsync/vsync/active (legal range 0..4)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
pix_en  output  1  one-clk pixel-rate enable
h_readwire  output  10  horizontal counter, 0..H_TOTAL-1
v_readwire  output  10  vertical counter, 0..V_TOTAL-1
hsync  output  1  horizontal sync, delayed by PIPE_DLY
vsync  output  1  vertical sync, delayed by PIPE_DLY
active  output  1  visible-area flag, delayed by PIPE_DLY
line_start  output  1  one-clk pulse after h wraps to 0
frame_start  output  1  one-clk pulse after (h,v) wraps to (0,0)
frame_count  output  8  completed-frame counter, for game tick

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be ≤ 1024; the counters are 10 bits.
- Reset values (async, on rst high):
  - divider = 0, pix_en = 0.
  - h = v = 0, frame_count = 0.
  - hsync = vsync = ~SYNC_POL, i.e. deasserted.
  - active = 0, line_start = frame_start = 0.
  - Every delay stage is cleared to the deasserted/0 value.
- Reset asserted mid-frame clears all of the above immediately, regardless of divider phase.
- Divider:
  - A counter runs 0..CLK_DIV-1.
  - pix_en is a registered output, high for exactly one clk when the divider wraps.
  - After rst deasserts, the first pix_en occurs on the CLK_DIV-th rising edge.
  - With CLK_DIV=1, pix_en is constantly 1 after the first edge.
- Counters update only on clk edges where pix_en is high:
  - h increments; at H_TOTAL-1, h goes to 0 and v increments.
  - At (H_TOTAL-1, V_TOTAL-1) both wrap to 0 and frame_count increments, 255 wraps to 0.
- Raw decode from the registered counters:
  - hs_raw = (H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC), i.e. h in 656..751.
  - vs_raw = v in 490..491.
  - act_raw = (h < H_ACTIVE) & (v < V_ACTIVE).
- Delay:
  - PIPE_DLY=0: outputs are the raw decode (hsync = hs_raw ? SYNC_POL : ~SYNC_POL).
  - Otherwise: PIPE_DLY registers, all enabled by pix_en, so outputs lag the counters by exactly PIPE_DLY pixels.
- Strobes:
  - line_start is high for one clk in the cycle after the edge that sets h=0 by wrap.
  - frame_start is the same, for the wrap to (0,0).
  - Both are registered and undelayed.
  - Neither pulses on the (0,0) state produced by reset.
- With counters at the wrap point and rst rising on the same edge, reset wins: no strobe and no frame_count increment.
- Counters never take values ≥ H_TOTAL or V_TOTAL.

Test Plan:
- Reset/idle: rst high 5 clks, release -> all outputs at reset values; pix_en first high on 2nd clk edge, then every 2nd clk; h=1 after first pix_en edge.
- Line timing (defaults): run one line -> hsync low (SYNC_POL=0) for exactly 96 pix_en with PIPE_DLY=1; low first seen when h=657; active high for 640 pix_en per visible line; line_start every 1600 clks.
- Frame timing: run 2 frames -> frame_start period 840000 clks; vsync low for 2 lines (1600 pix_en) beginning when v=490 plus 1-pixel lag; frame_count = 2; no active in lines 480..524.
- Delay/polarity sweep: PIPE_DLY=0,3 with SYNC_POL=1 -> hsync high starting at h=656 and h=659 respectively; active falls at h=640 and h=643.
- Reset mid-frame: assert rst at h=300, v=200, between pix_en pulses -> same-cycle async clear to reset values, no frame_start; after release, scan restarts from (0,0) with correct cadence.
- Wrap edge: 256 frames -> frame_count returns to 0; h and v never exceed 799 and 524 (assertion checks throughout).

Source files
------------

// File: rtl/vga_timing_gen.sv
`default_nettype none
// vga_timing_gen: raster counters paced by an internal pixel clock-enable, sync/active
// decode with a pixel-enabled alignment delay, line/frame strobes and a frame counter.
module vga_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter int   CLK_DIV  = 2,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIPE_DLY = 1
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_en,
    output logic [9:0] h_readwire,
    output logic [9:0] v_readwire,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  C_H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  C_V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [2:0]  C_DIV_LAST = 3'(CLK_DIV - 1);
    localparam logic [10:0] C_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] C_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] C_HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] C_HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] C_VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] C_VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [2:0] div_q, div_d;
    logic       pix_en_q, pix_en_d;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic [7:0] fc_q, fc_d;
    logic       ls_q, ls_d, fs_q, fs_d;
    logic       h_wrap, v_wrap;
    logic       hs_raw, vs_raw, act_raw;
    logic       hs_out, vs_out, act_out;

    always_comb begin
        h_wrap   = (h_q == C_H_LAST);
        v_wrap   = (v_q == C_V_LAST);
        div_d    = (div_q == C_DIV_LAST) ? 3'd0 : div_q + 3'd1;
        pix_en_d = (div_q == C_DIV_LAST);
        h_d      = h_q;
        v_d      = v_q;
        fc_d     = fc_q;
        ls_d     = 1'b0;
        fs_d     = 1'b0;
        if (pix_en_q) begin
            if (h_wrap) begin
                h_d  = 10'd0;
                ls_d = 1'b1;
                if (v_wrap) begin
                    v_d  = 10'd0;
                    fs_d = 1'b1;
                    fc_d = fc_q + 8'd1;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q    <= 3'd0;
            pix_en_q <= 1'b0;
            h_q      <= 10'd0;
            v_q      <= 10'd0;
            fc_q     <= 8'd0;
            ls_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            pix_en_q <= pix_en_d;
            h_q      <= h_d;
            v_q      <= v_d;
            fc_q     <= fc_d;
            ls_q     <= ls_d;
            fs_q     <= fs_d;
        end
    end

    always_comb begin
        hs_raw  = ({1'b0, h_q} >= C_HS_BEG) && ({1'b0, h_q} < C_HS_END);
        vs_raw  = ({1'b0, v_q} >= C_VS_BEG) && ({1'b0, v_q} < C_VS_END);
        act_raw = ({1'b0, h_q} < C_H_ACT) && ({1'b0, v_q} < C_V_ACT);
    end

    // Stages hold "asserted" flags; polarity is applied only at the output.
    generate
        if (PIPE_DLY == 0) begin : g_nodly
            assign {hs_out, vs_out, act_out} = {hs_raw, vs_raw, act_raw};
        end else begin : g_dly
            logic [2:0] dly_q [PIPE_DLY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < PIPE_DLY; i++) dly_q[i] <= 3'b000;
                end else if (pix_en_q) begin
                    dly_q[0] <= {hs_raw, vs_raw, act_raw};
                    for (int i = 1; i < PIPE_DLY; i++) dly_q[i] <= dly_q[i-1];
                end
            end
            assign {hs_out, vs_out, act_out} = dly_q[PIPE_DLY-1];
        end
    endgenerate

    assign pix_en      = pix_en_q;
    assign h_readwire  = h_q;
    assign v_readwire  = v_q;
    assign hsync       = hs_out ? SYNC_POL : ~SYNC_POL;
    assign vsync       = vs_out ? SYNC_POL : ~SYNC_POL;
    assign active      = act_out;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_count = fc_q;
endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// tb_vga_timing_gen: directed checks of a default-timing instance and two small-raster
// instances (different divider, delay and sync polarity) sharing one clock and reset.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic       a_pix, a_hs, a_vs, a_act, a_ls, a_fs;
    logic [9:0] a_h, a_v;
    logic [7:0] a_fc;
    logic       b_pix, b_hs, b_vs, b_act, b_ls, b_fs;
    logic [9:0] b_h, b_v;
    logic [7:0] b_fc;
    logic       c_pix, c_hs, c_vs, c_act, c_ls, c_fs;
    logic [9:0] c_h, c_v;
    logic [7:0] c_fc;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst), .pix_en(a_pix), .h_readwire(a_h), .v_readwire(a_v),
        .hsync(a_hs), .vsync(a_vs), .active(a_act), .line_start(a_ls),
        .frame_start(a_fs), .frame_count(a_fc)
    );

    // 16x8 raster: hsync h=10..12, vsync v=5..6, active h<8 & v<4
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(1), .SYNC_POL(1'b1), .PIPE_DLY(3)
    ) u_b (
        .clk(clk), .rst(rst), .pix_en(b_pix), .h_readwire(b_h), .v_readwire(b_v),
        .hsync(b_hs), .vsync(b_vs), .active(b_act), .line_start(b_ls),
        .frame_start(b_fs), .frame_count(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .CLK_DIV(3), .SYNC_POL(1'b1), .PIPE_DLY(0)
    ) u_c (
        .clk(clk), .rst(rst), .pix_en(c_pix), .h_readwire(c_h), .v_readwire(c_v),
        .hsync(c_hs), .vsync(c_vs), .active(c_act), .line_start(c_ls),
        .frame_start(c_fs), .frame_count(c_fc)
    );

    int max_ah = 0, max_bh = 0, max_bv = 0, max_ch = 0, max_cv = 0;
    always @(negedge clk) begin
        if (int'(a_h) > max_ah) max_ah = int'(a_h);
        if (int'(b_h) > max_bh) max_bh = int'(b_h);
        if (int'(b_v) > max_bv) max_bv = int'(b_v);
        if (int'(c_h) > max_ch) max_ch = int'(c_h);
        if (int'(c_v) > max_cv) max_cv = int'(c_v);
    end

    initial begin
        int k, cnt_hs, cnt_act, cnt_ls, cnt_vs, cnt_bad, first_hs, first_vs, fall_act, nfs;
        logic prev_act;
        logic [7:0] fc0;

        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_a_pix", a_pix, 0);
        chk("rst_a_h", a_h, 0);
        chk("rst_a_v", a_v, 0);
        chk("rst_a_hsync", a_hs, 1);
        chk("rst_a_vsync", a_vs, 1);
        chk("rst_a_active", a_act, 0);
        chk("rst_a_strobes", {a_ls, a_fs}, 0);
        chk("rst_a_fc", a_fc, 0);
        chk("rst_b_hsync", b_hs, 0);
        chk("rst_c_vsync", c_vs, 0);

        // Divider cadence and first counter step
        @(negedge clk) rst = 1'b0;
        @(posedge clk) #1;
        chk("e1_a_pix", a_pix, 0);
        chk("e1_b_pix", b_pix, 1);
        chk("e1_b_h", b_h, 0);
        @(posedge clk) #1;
        chk("e2_a_pix", a_pix, 1);
        chk("e2_a_h", a_h, 0);
        chk("e2_a_active", a_act, 0);
        chk("e2_b_h", b_h, 1);
        @(posedge clk) #1;
        chk("e3_a_pix", a_pix, 0);
        chk("e3_a_h", a_h, 1);
        chk("e3_a_active", a_act, 1);
        chk("e3_a_ls", a_ls, 0);
        @(posedge clk) #1;
        chk("e4_a_pix", a_pix, 1);

        // Default line timing over one full line
        k = 0;
        while (!a_ls && k < 4000) begin @(negedge clk); k++; end
        chk("a_ls_seen", a_ls, 1);
        cnt_hs = 0; cnt_act = 0; cnt_ls = 0; first_hs = -1;
        for (int i = 0; i < 1600; i++) begin
            if (a_pix && !a_hs) cnt_hs++;
            if (a_pix && a_act) cnt_act++;
            if (!a_hs && first_hs < 0) first_hs = int'(a_h);
            if (a_ls) cnt_ls++;
            @(negedge clk);
        end
        chk("a_hsync_len", cnt_hs, 96);
        chk("a_active_len", cnt_act, 640);
        chk("a_hsync_first_h", first_hs, 657);
        chk("a_ls_per_line", cnt_ls, 1);
        chk("a_ls_period", a_ls, 1);
        chk("a_v_after_line", a_v, 2);
        chk("a_vsync_idle", a_vs, 1);

        // Small raster B: CLK_DIV=1, PIPE_DLY=3, active-high sync
        k = 0;
        while (!b_fs && k < 300) begin @(negedge clk); k++; end
        chk("b_fs_seen", b_fs, 1);
        fc0 = b_fc;
        cnt_vs = 0; cnt_act = 0; cnt_bad = 0; first_hs = -1; first_vs = -1; fall_act = -1;
        prev_act = b_act;
        for (int i = 0; i < 128; i++) begin
            if (b_pix && b_vs) cnt_vs++;
            if (b_pix && b_act) cnt_act++;
            if (b_act && b_v >= 10'd4) cnt_bad++;
            if (b_hs && first_hs < 0) first_hs = int'(b_h);
            if (b_vs && first_vs < 0) first_vs = int'(b_v) * 16 + int'(b_h);
            if (prev_act && !b_act && fall_act < 0) fall_act = int'(b_h);
            prev_act = b_act;
            @(negedge clk);
        end
        chk("b_vsync_len", cnt_vs, 32);
        chk("b_active_len", cnt_act, 32);
        chk("b_active_blank", cnt_bad, 0);
        chk("b_hsync_first_h", first_hs, 13);
        chk("b_vsync_first_pos", first_vs, 83);
        chk("b_active_fall_h", fall_act, 11);
        chk("b_fs_period", b_fs, 1);
        chk("b_fc_step", b_fc, 32'(8'(fc0 + 8'd1)));

        // Small raster C: CLK_DIV=3, PIPE_DLY=0, active-high sync
        k = 0;
        while (!c_fs && k < 1000) begin @(negedge clk); k++; end
        chk("c_fs_seen", c_fs, 1);
        cnt_hs = 0; first_hs = -1; fall_act = -1;
        prev_act = c_act;
        for (int i = 0; i < 384; i++) begin
            if (c_pix && c_hs) cnt_hs++;
            if (c_hs && first_hs < 0) first_hs = int'(c_h);
            if (prev_act && !c_act && fall_act < 0) fall_act = int'(c_h);
            prev_act = c_act;
            @(negedge clk);
        end
        chk("c_hsync_len", cnt_hs, 24);
        chk("c_hsync_first_h", first_hs, 10);
        chk("c_active_fall_h", fall_act, 8);
        chk("c_fs_period", c_fs, 1);

        // Mid-frame asynchronous reset between C pixel enables
        k = 0;
        while (!(c_h == 10'd5 && c_v == 10'd3 && !c_pix) && k < 2000) begin
            @(negedge clk); k++;
        end
        chk("c_midframe_reached", {c_h == 10'd5, c_v == 10'd3}, 32'b11);
        rst = 1'b1;
        #1;
        chk("mr_c_h", c_h, 0);
        chk("mr_c_v", c_v, 0);
        chk("mr_c_fc", c_fc, 0);
        chk("mr_c_hsync", c_hs, 0);
        chk("mr_a_h", a_h, 0);
        chk("mr_a_hsync", a_hs, 1);
        chk("mr_a_active", a_act, 0);
        chk("mr_b_fc", b_fc, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("mr_strobes", {c_ls, c_fs, b_fs, a_fs}, 0);
        @(negedge clk) rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rel_c_pix_e2", c_pix, 0);
        @(posedge clk) #1;
        chk("rel_c_pix_e3", c_pix, 1);
        chk("rel_c_h_e3", c_h, 0);
        @(posedge clk) #1;
        chk("rel_c_pix_e4", c_pix, 0);
        chk("rel_c_h_e4", c_h, 1);

        // Frame counter wrap on B
        nfs = 0; k = 0;
        while (nfs < 256 && k < 256 * 128 + 400) begin
            @(negedge clk);
            k++;
            if (b_fs) begin
                nfs++;
                if (nfs == 128) chk("b_fc_half", b_fc, 128);
            end
        end
        chk("b_fs_count", nfs, 256);
        chk("b_fc_wrap", b_fc, 0);

        chk("a_max_h", max_ah, 799);
        chk("b_max_h", max_bh, 15);
        chk("b_max_v", max_bv, 7);
        chk("c_max_h", max_ch, 15);
        chk("c_max_v", max_cv, 7);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
